pulse_button_bank: RTL and testbench

- Parametrised multi-channel successor to the single-button rising-edge pulser.
- Per channel: input synchroniser, counter-based debouncer, selectable edge detection, and optional auto-repeat while held.
- Emits single-cycle pulses and a debounced level per channel.
- Sits between raw board buttons/switches and bootloader/control logic on the system clock.

---
 rtl/pulse_button_bank.sv | 128 ++++++++++++
 tb/tb_pulse_button_bank.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_button_bank.sv
// Multi-channel button front end: synchroniser, counter debouncer, selectable
// edge pulses and optional auto-repeat, one independent lane per channel.
module pulse_button_bank #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EDGE_MODE       = 0,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic            any_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DLY_W = (REPEAT_DELAY == 0) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam int unsigned PER_W = $clog2(REPEAT_PERIOD + 1);

    localparam bit RISE_EN = (EDGE_MODE != 1);
    localparam bit FALL_EN = (EDGE_MODE != 0);
    localparam bit REP_EN  = (REPEAT_DELAY != 0) && (EDGE_MODE != 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(REPEAT_PERIOD - 1);

    logic [N_CH-1:0] pulse_d;
    logic [N_CH-1:0] pulse_q;
    logic            any_pulse_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic [DLY_W-1:0]       dly_q, dly_d;
        logic [PER_W-1:0]       per_q, per_d;
        logic                   rep_q, rep_d;
        logic                   s;
        logic                   rise_ev, fall_ev, rep_fire, ev_pulse;

        assign s = sync_q[SYNC_STAGES-1];

        // Next-state: debounce acceptance, then the delay/period repeat schedule.
        always_comb begin
            sync_d   = {sync_q[SYNC_STAGES-2:0], button[i]};
            cnt_d    = '0;
            level_d  = level_q;
            dly_d    = '0;
            per_d    = '0;
            rep_d    = 1'b0;
            rise_ev  = 1'b0;
            fall_ev  = 1'b0;
            rep_fire = 1'b0;

            if (s != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    rise_ev = s;
                    fall_ev = !s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A release in progress of acceptance cancels any repeat this cycle.
            if (REP_EN && level_q && !fall_ev) begin
                if (!rep_q) begin
                    if (dly_q == DLY_LAST) begin
                        rep_fire = 1'b1;
                        rep_d    = 1'b1;
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end else begin
                    rep_d = 1'b1;
                    if (per_q == PER_LAST) begin
                        rep_fire = 1'b1;
                    end else begin
                        per_d = per_q + PER_W'(1);
                    end
                end
            end

            ev_pulse = en && ((RISE_EN && rise_ev) || (FALL_EN && fall_ev) || rep_fire);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                dly_q   <= '0;
                per_q   <= '0;
                rep_q   <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                dly_q   <= dly_d;
                per_q   <= per_d;
                rep_q   <= rep_d;
            end
        end

        assign pulse_d[i] = ev_pulse;
        assign level[i]   = level_q;
    end

    // Pulse and its OR-reduction are registered together so they stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_q     <= '0;
            any_pulse_q <= 1'b0;
        end else begin
            pulse_q     <= pulse_d;
            any_pulse_q <= |pulse_d;
        end
    end

    assign pulse     = pulse_q;
    assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_pulse_button_bank.sv
// Bench for pulse_button_bank: three configurations share one stimulus stream and
// are checked every cycle against an event-level reference model.
module tb_pulse_button_bank;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PER  = 4;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            en     = 1'b1;
    logic [N_CH-1:0] button = '0;

    logic [N_CH-1:0] level_a, pulse_a, level_b, pulse_b, level_c, pulse_c;
    logic            any_a, any_b, any_c;

    always #5 clk = ~clk;

    pulse_button_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                        .EDGE_MODE(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(PER)) dut_a (
        .clk(clk), .reset(reset), .en(en), .button(button),
        .level(level_a), .pulse(pulse_a), .any_pulse(any_a));

    pulse_button_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                        .EDGE_MODE(2), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER)) dut_b (
        .clk(clk), .reset(reset), .en(en), .button(button),
        .level(level_b), .pulse(pulse_b), .any_pulse(any_b));

    pulse_button_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                        .EDGE_MODE(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(PER)) dut_c (
        .clk(clk), .reset(reset), .en(en), .button(button),
        .level(level_c), .pulse(pulse_c), .any_pulse(any_c));

    logic [N_CH-1:0] obs_lvl [3];
    logic [N_CH-1:0] obs_pls [3];
    logic            obs_any [3];
    assign obs_lvl[0] = level_a;
    assign obs_lvl[1] = level_b;
    assign obs_lvl[2] = level_c;
    assign obs_pls[0] = pulse_a;
    assign obs_pls[1] = pulse_b;
    assign obs_pls[2] = pulse_c;
    assign obs_any[0] = any_a;
    assign obs_any[1] = any_b;
    assign obs_any[2] = any_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: input delay line plus per-instance event bookkeeping.
    int              cfg_mode [3];
    int              cfg_dly  [3];
    logic [N_CH-1:0] dline    [SYNC];
    logic            m_lvl    [3][N_CH];
    int              m_run    [3][N_CH];
    logic            m_held   [3][N_CH];
    int              m_tp     [3][N_CH];
    logic [N_CH-1:0] exp_lvl  [3];
    logic [N_CH-1:0] exp_pls  [3];
    int              cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < SYNC; k++) dline[k] = '0;
        for (int j = 0; j < 3; j++) begin
            exp_lvl[j] = '0;
            exp_pls[j] = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_lvl[j][c]  = 1'b0;
                m_run[j][c]  = 0;
                m_held[j][c] = 1'b0;
                m_tp[j][c]   = 0;
            end
        end
    endtask

    // One clock edge of the model: a level flips after DEB consecutive differing
    // samples; repeats fall at press + delay + k*period while still held.
    task automatic model_edge();
        logic [N_CH-1:0] s;
        logic rise, fall, rep;
        int age;
        if (!reset) begin
            model_clear();
        end else begin
            s = dline[0];
            for (int k = 0; k < SYNC - 1; k++) dline[k] = dline[k+1];
            dline[SYNC-1] = button;
            cyc++;
            for (int j = 0; j < 3; j++) begin
                for (int c = 0; c < N_CH; c++) begin
                    rise = 1'b0;
                    fall = 1'b0;
                    if (s[c] != m_lvl[j][c]) begin
                        m_run[j][c]++;
                        if (m_run[j][c] == DEB) begin
                            m_lvl[j][c] = s[c];
                            m_run[j][c] = 0;
                            rise = s[c];
                            fall = !s[c];
                        end
                    end else begin
                        m_run[j][c] = 0;
                    end
                    if (rise) begin
                        m_held[j][c] = 1'b1;
                        m_tp[j][c]   = cyc;
                    end
                    if (fall) m_held[j][c] = 1'b0;
                    age = cyc - m_tp[j][c];
                    rep = (cfg_dly[j] > 0) && (cfg_mode[j] != 1) && m_held[j][c] && !rise &&
                          (age >= cfg_dly[j]) && (((age - cfg_dly[j]) % PER) == 0);
                    exp_lvl[j][c] = m_lvl[j][c];
                    exp_pls[j][c] = en && ((rise && cfg_mode[j] != 1) ||
                                           (fall && cfg_mode[j] != 0) || rep);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("level_%0d", j), 32'(obs_lvl[j]), 32'(exp_lvl[j]));
            check($sformatf("pulse_%0d", j), 32'(obs_pls[j]), 32'(exp_pls[j]));
            check($sformatf("any_pulse_%0d", j), 32'(obs_any[j]), 32'(|exp_pls[j]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int found;
        cfg_mode = '{0, 2, 1};
        cfg_dly  = '{10, 0, 10};
        model_clear();

        // Reset state, asserted before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_level", 32'(level_a), 32'h0);
        check("rst_pulse", 32'(pulse_b), 32'h0);
        check("rst_any",   32'(any_c),   32'h0);
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // Clean press on channel 0: pulse and level after edge SYNC+DEB.
        button[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("press_pulse_a", 32'(pulse_a), (k == 6) ? 32'h1 : 32'h0);
            check("press_any_a",   32'(any_a),   (k == 6) ? 32'h1 : 32'h0);
            check("press_level_a", 32'(level_a), (k == 6) ? 32'h1 : 32'h0);
        end
        step();
        check("press_width_a", 32'(pulse_a), 32'h0);
        button[0] = 1'b0;
        repeat (12) step();

        // Bounce on channel 1 rejected; one pulse 6 edges after the final stable 1.
        for (int k = 0; k < 4; k++) begin
            button[1] = (k % 2 == 0);
            step();
            check("bounce_quiet", 32'(pulse_a[1]), 32'h0);
        end
        button[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("bounce_pulse", 32'(pulse_a[1]), (k == 6) ? 32'h1 : 32'h0);
        end
        button[1] = 1'b0;
        repeat (12) step();

        // Both-edge mode on channel 2: exactly a press and a release pulse.
        cnt = 0;
        button[2] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            step();
            cnt += int'(pulse_b[2]);
        end
        button[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            cnt += int'(pulse_b[2]);
        end
        check("mode2_pulses", 32'(cnt), 32'd2);
        check("mode2_level", 32'(level_b[2]), 32'h0);

        // Auto-repeat on channel 3: t, t+10, t+14, t+18, t+22, t+26.
        button[3] = 1'b1;
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            step();
            if (pulse_a[3]) found = k;
        end
        check("repeat_press_latency", 32'(found), 32'd6);
        cnt = 1;
        for (int k = 1; k < 30; k++) begin
            step();
            cnt += int'(pulse_a[3]);
        end
        check("repeat_count", 32'(cnt), 32'd6);
        button[3] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!level_a[3]) cnt += int'(pulse_a[3]);
        end
        check("repeat_after_release", 32'(cnt), 32'd0);
        check("repeat_level_low", 32'(level_a[3]), 32'h0);

        // en low across press acceptance: level updates, press pulse lost, repeat resumes.
        en = 1'b0;
        button[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("en_gate_a", 32'(pulse_a), 32'h0);
            check("en_gate_b", 32'(pulse_b), 32'h0);
        end
        check("en_level", 32'(level_a), 32'h1);
        en = 1'b1;
        for (int k = 7; k <= 16; k++) begin
            step();
            check("en_resume", 32'(pulse_a), (k == 16) ? 32'h1 : 32'h0);
        end
        button[0] = 1'b0;
        repeat (14) step();

        // Async reset mid-repeat (ch3) and mid-debounce (ch2).
        button[3] = 1'b1;
        repeat (20) step();
        button[2] = 1'b1;
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        check("arst_level_a", 32'(level_a), 32'h0);
        check("arst_pulse_a", 32'(pulse_a), 32'h0);
        check("arst_any_a",   32'(any_a),   32'h0);
        check("arst_level_b", 32'(level_b), 32'h0);
        model_clear();
        repeat (2) step();
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("arst_rel_a", 32'(pulse_a), (k == 6) ? 32'hC : 32'h0);
            check("arst_rel_b", 32'(pulse_b), (k == 6) ? 32'hC : 32'h0);
        end
        button = '0;
        repeat (12) step();

        // Randomised holds, bounces and enable toggling.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 11) == 0) button[c] = ~button[c];
            end
            en = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
